// File: rtl/button_conditioner.sv
// Two-flop synchroniser plus per-channel debounce FSM producing a clean level and a one-cycle press pulse.
// Optional auto-repeat of the press pulse is enabled by defining BUTTON_CONDITIONER_AUTO_REPEAT_EN.
module button_conditioner #(
  parameter int N_BTN           = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int REPEAT_DELAY    = 256,
  parameter int REPEAT_PERIOD   = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_SAT  = {CNT_W{1'b1}};

  localparam bit PARAMS_OK = (N_BTN >= 1) &&
                             (DEBOUNCE_CYCLES >= 2) && (DEBOUNCE_CYCLES <= 65535) &&
                             (REPEAT_DELAY >= 1) && (REPEAT_PERIOD >= 1);

  if (!PARAMS_OK) begin : g_bad_params
    $error("button_conditioner: illegal parameter combination");
  end

  typedef enum logic [1:0] {
    IDLE,
    ARM_PRESS,
    HELD,
    ARM_RELEASE
  } state_e;

  logic [N_BTN-1:0] sync1_q;
  logic [N_BTN-1:0] sync2_q;

  // Only sync2_q is allowed to feed the debounce logic.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
    end
  end

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic             press_evt;
    logic             sample;

    assign sample = sync2_q[i];

    always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      level_d   = level_q;
      press_evt = 1'b0;
      unique case (state_q)
        IDLE: begin
          if (sample) begin
            state_d = ARM_PRESS;
            cnt_d   = CNT_W'(1);
          end
        end
        ARM_PRESS: begin
          if (!sample) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else if (cnt_q == CNT_LAST) begin
            state_d   = HELD;
            cnt_d     = '0;
            level_d   = 1'b1;
            press_evt = 1'b1;
          end else if (cnt_q != CNT_SAT) begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        HELD: begin
          if (!sample) begin
            state_d = ARM_RELEASE;
            cnt_d   = CNT_W'(1);
          end
        end
        ARM_RELEASE: begin
          if (sample) begin
            state_d = HELD;
            cnt_d   = '0;
          end else if (cnt_q == CNT_LAST) begin
            state_d = IDLE;
            cnt_d   = '0;
            level_d = 1'b0;
          end else if (cnt_q != CNT_SAT) begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      endcase
    end

`ifdef BUTTON_CONDITIONER_AUTO_REPEAT_EN
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RPT_W   = $clog2(RPT_MAX + 1);
    localparam logic [RPT_W-1:0] RPT_DELAY_LAST  = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] RPT_PERIOD_LAST = RPT_W'(REPEAT_PERIOD - 1);

    logic [RPT_W-1:0] rpt_q, rpt_d;
    logic             rpt_phase_q, rpt_phase_d;
    logic             rpt_fire;

    // Timer restarts on a fresh press; a pulse due on the edge that returns to IDLE is suppressed.
    always_comb begin
      rpt_d       = rpt_q;
      rpt_phase_d = rpt_phase_q;
      rpt_fire    = 1'b0;
      if (state_d == IDLE || state_d == ARM_PRESS || state_q == ARM_PRESS) begin
        rpt_d       = '0;
        rpt_phase_d = 1'b0;
      end else if (rpt_q == (rpt_phase_q ? RPT_PERIOD_LAST : RPT_DELAY_LAST)) begin
        rpt_fire    = 1'b1;
        rpt_d       = '0;
        rpt_phase_d = 1'b1;
      end else begin
        rpt_d = rpt_q + RPT_W'(1);
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        rpt_q       <= '0;
        rpt_phase_q <= 1'b0;
      end else begin
        rpt_q       <= rpt_d;
        rpt_phase_q <= rpt_phase_d;
      end
    end

    assign press_d = press_evt | rpt_fire;
`else
    assign press_d = press_evt;
`endif

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state_q <= IDLE;
        cnt_q   <= '0;
        level_q <= 1'b0;
        press_q <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        level_q <= level_d;
        press_q <= press_d;
      end
    end

    assign btn_level[i] = level_q;
    assign btn_press[i] = press_q;
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed self-checking bench for button_conditioner with DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8.
// Expected pulse positions follow the auto-repeat setting selected by BUTTON_CONDITIONER_AUTO_REPEAT_EN.
module tb_button_conditioner;

`ifdef BUTTON_CONDITIONER_AUTO_REPEAT_EN
  localparam bit REPEAT_ON = 1'b1;
`else
  localparam bit REPEAT_ON = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic [1:0] btn_raw;
  logic [1:0] btn_level;
  logic [1:0] btn_press;

  int testsRun;
  int testsFailed;
  int pulseCount;

  button_conditioner #(
    .N_BTN          (2),
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY   (20),
    .REPEAT_PERIOD  (8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .btn_raw  (btn_raw),
    .btn_level(btn_level),
    .btn_press(btn_press)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Press pulse expected j edges after the raw input is first sampled high, while the button stays held.
  function automatic logic expPress(input int j);
    return (j == 5) || (REPEAT_ON && j >= 25 && ((j - 25) % 8) == 0);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] raw);
    @(negedge clk);
    btn_raw = raw;
  endtask

  task automatic stepEdge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    testsRun    = 0;
    testsFailed = 0;
    rst         = 1'b1;
    btn_raw     = 2'b00;

    // Reset state
    #1;
    checkOutput("reset_level_async", 32'(btn_level), 32'd0);
    checkOutput("reset_press_async", 32'(btn_press), 32'd0);
    repeat (3) stepEdge();
    checkOutput("reset_level", 32'(btn_level), 32'd0);
    checkOutput("reset_press", 32'(btn_press), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Test 1: clean press on channel 0, held 51 edges
    applyStimulus(2'b01);
    for (int j = 0; j <= 50; j++) begin
      stepEdge();
      checkOutput("t1_press", 32'(btn_press), {31'd0, expPress(j)});
      checkOutput("t1_level", 32'(btn_level), (j >= 5) ? 32'd1 : 32'd0);
    end

    // Test 3: release with a one-sample glitch two cycles in
    for (int j = 0; j <= 11; j++) begin
      applyStimulus({1'b0, (j == 2)});
      stepEdge();
      checkOutput("t3_level", 32'(btn_level), (j < 8) ? 32'd1 : 32'd0);
      checkOutput("t3_press", 32'(btn_press), {31'd0, (j < 8) && expPress(51 + j)});
    end

    // Test 2: bounce on channel 1, never four consecutive highs
    for (int j = 0; j <= 19; j++) begin
      applyStimulus({(j < 16) && ((j % 4) != 3), 1'b0});
      stepEdge();
      checkOutput("t2_level", 32'(btn_level), 32'd0);
      checkOutput("t2_press", 32'(btn_press), 32'd0);
    end

    // Test 4: simultaneous press on both channels, then release
    applyStimulus(2'b11);
    for (int j = 0; j <= 7; j++) begin
      stepEdge();
      checkOutput("t4_press", 32'(btn_press), (j == 5) ? 32'd3 : 32'd0);
      checkOutput("t4_level", 32'(btn_level), (j >= 5) ? 32'd3 : 32'd0);
    end
    for (int j = 8; j <= 22; j++) begin
      applyStimulus(2'b00);
      stepEdge();
      checkOutput("t4_rel_press", 32'(btn_press), 32'd0);
      if (j == 12) checkOutput("t4_level_last_high", 32'(btn_level), 32'd3);
      if (j == 13) checkOutput("t4_level_first_low", 32'(btn_level), 32'd0);
    end
    checkOutput("t4_level_end", 32'(btn_level), 32'd0);

    // Test 5: reset while channel 0 is held high
    applyStimulus(2'b01);
    for (int j = 0; j <= 6; j++) stepEdge();
    checkOutput("t5_level_before", 32'(btn_level), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("t5_level_async", 32'(btn_level), 32'd0);
    checkOutput("t5_press_async", 32'(btn_press), 32'd0);
    stepEdge();
    checkOutput("t5_level_in_rst", 32'(btn_level), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int j = 1; j <= 8; j++) begin
      stepEdge();
      checkOutput("t5_press_after", 32'(btn_press), (j == 6) ? 32'd1 : 32'd0);
      checkOutput("t5_level_after", 32'(btn_level), (j >= 6) ? 32'd1 : 32'd0);
    end

    // Test 6: long hold of 60 samples, counting pulses
    @(negedge clk);
    rst     = 1'b1;
    btn_raw = 2'b00;
    @(negedge clk);
    rst = 1'b0;
    pulseCount = 0;
    for (int j = 0; j <= 74; j++) begin
      applyStimulus((j < 60) ? 2'b01 : 2'b00);
      stepEdge();
      if (btn_press[0]) pulseCount++;
      checkOutput("t6_press", 32'(btn_press), {31'd0, (j <= 60) && expPress(j)});
    end
    checkOutput("t6_pulse_count", 32'(pulseCount), REPEAT_ON ? 32'd6 : 32'd1);
    checkOutput("t6_level_end", 32'(btn_level), 32'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
